// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one radix-2 step per cycle, with divide-by-zero and signed-overflow shortcuts.
//
// state | meaning
// IDLE  | ready for a request; special cases jump straight to DONE
// CALC  | one multiply/divide iteration per cycle while the counter runs down
// DONE  | result presented with a one-cycle o_valid pulse
module muldiv_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] M_MUL    = 3'b000,
  parameter logic [2:0] M_MULH   = 3'b001,
  parameter logic [2:0] M_MULHSU = 3'b010,
  parameter logic [2:0] M_MULHU  = 3'b011,
  parameter logic [2:0] M_DIV    = 3'b100,
  parameter logic [2:0] M_DIVU   = 3'b101,
  parameter logic [2:0] M_REM    = 3'b110,
  parameter logic [2:0] M_REMU   = 3'b111
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_md_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_md_data
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [2:0]           op_q;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]     opb;
  logic                 neg_q, neg_rem_q;
  logic [WIDTH-1:0]     res_q, out_q;

  logic                 accept;
  logic                 in_div, in_signed_a, in_signed_b, in_sign_a, in_sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 div_zero, div_ovf, special;
  logic [WIDTH-1:0]     special_res;

  logic [WIDTH:0]       add_sum, shl_rem, sub_diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem, final_res;

  assign accept = (state == IDLE) && i_valid && !i_flush;

  // Request decode: signedness, magnitudes and the no-iteration shortcuts.
  always_comb begin
    in_div      = i_md_op[2];
    in_signed_a = (i_md_op == M_MULH) || (i_md_op == M_MULHSU) ||
                  (i_md_op == M_DIV)  || (i_md_op == M_REM);
    in_signed_b = (i_md_op == M_MULH) || (i_md_op == M_DIV) || (i_md_op == M_REM);
    in_sign_a   = in_signed_a && i_operand_a[WIDTH-1];
    in_sign_b   = in_signed_b && i_operand_b[WIDTH-1];
    mag_a       = in_sign_a ? -i_operand_a : i_operand_a;
    mag_b       = in_sign_b ? -i_operand_b : i_operand_b;
    div_zero    = in_div && (i_operand_b == '0);
    div_ovf     = ((i_md_op == M_DIV) || (i_md_op == M_REM)) &&
                  (i_operand_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (i_operand_b == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = ((i_md_op == M_DIV) || (i_md_op == M_DIVU)) ? '1 : i_operand_a;
    else if (div_ovf)
      special_res = (i_md_op == M_DIV) ? i_operand_a : '0;
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    shl_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    sub_diff = shl_rem - {1'b0, opb};
    if (op_q[2]) begin
      if (sub_diff[WIDTH])
        acc_nxt = {shl_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_nxt = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod      = neg_q ? -acc_nxt : acc_nxt;
    quo       = acc_nxt[WIDTH-1:0];
    rem       = acc_nxt[2*WIDTH-1:WIDTH];
    final_res = '0;
    case (op_q)
      M_MUL:                      final_res = prod[WIDTH-1:0];
      M_MULH, M_MULHSU, M_MULHU:  final_res = prod[2*WIDTH-1:WIDTH];
      M_DIV, M_DIVU:              final_res = neg_q ? -quo : quo;
      default:                    final_res = neg_rem_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid && !i_flush) state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        if (i_flush)                  state_nxt = IDLE;
        else if (cnt == CNT_W'(1))    state_nxt = DONE;
      end
      DONE: begin
        // A flush in this cycle kills the pulse and leaves the held result alone.
        o_valid   = !i_flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_md_data = o_valid ? res_q : out_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q      <= M_MUL;
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
      out_q     <= '0;
    end else begin
      if (accept) begin
        op_q      <= i_md_op;
        neg_q     <= in_sign_a ^ in_sign_b;
        neg_rem_q <= in_sign_a;
        if (special) begin
          cnt   <= '0;
          res_q <= special_res;
        end else begin
          cnt <= CNT_W'(WIDTH);
          acc <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
          opb <= in_div ? mag_b : mag_a;
        end
      end else if (state == CALC && !i_flush) begin
        acc <= acc_nxt;
        if (cnt != '0)          cnt   <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1))   res_q <= final_res;
      end
      if (o_valid) out_q <= res_q;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected results are queued at request
// time and matched (value and latency) when o_valid pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [2:0]  md_op = 3'b000;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        out_valid;
  logic [31:0] md_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  muldiv_unit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_md_op     (md_op),
    .i_operand_a (operand_a),
    .i_operand_b (operand_b),
    .o_valid     (out_valid),
    .o_md_data   (md_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_v, p;
    logic [63:0] up;
    int          ia, ib;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    ia   = $signed(a);
    ib   = $signed(b);
    up   = {32'h0, a} * {32'h0, b};
    model = '0;
    case (op)
      3'b000: model = up[31:0];
      3'b001: begin p = sa * sb_v; model = p[63:32]; end
      3'b010: begin p = sa * longint'({32'h0, b}); model = p[63:32]; end
      3'b011: model = up[63:32];
      3'b100: if (b == 0) model = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = a;
              else model = ia / ib;
      3'b101: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: if (b == 0) model = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h0;
              else model = ia % ib;
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard: every o_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      valid_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: data=%h at cycle %0d, nothing expected", md_data, cyc);
      end else begin
        e = sb.pop_front();
        if (md_data !== e.data) begin
          failures++;
          $display("FAIL %s data: got %h expected %h", e.name, md_data, e.data);
        end
        checks++;
        if (cyc != e.due) begin
          failures++;
          $display("FAIL %s latency: valid at cycle %0d expected %0d", e.name, cyc, e.due);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input string name, input bit hold,
                       output int stamp);
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s ready_timeout: ready=%b expected 1", name, ready);
    end
    md_op = op;
    operand_a = a;
    operand_b = b;
    valid = 1'b1;
    stamp = cyc;
    sb.push_back('{exp_d, cyc + (is_special(op, a, b) ? 1 : 33), name});
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (md_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", md_data); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_mul();
    int st;
    int n = 0;
    issue(3'b000, 32'd7, 32'd6, 32'd42, "mul_7x6", 1'b0, st);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL mul_ready_low: got %b expected 0", ready); end
    while (out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL mul_ready_back: got %b expected 1", ready); end
    drain();
  endtask

  task automatic test_mulh();
    int st;
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1m1", 1'b0, st);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max", 1'b0, st);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu_m1x2", 1'b0, st);
    drain();
  endtask

  task automatic test_div();
    int st;
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2", 1'b0, st);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2", 1'b0, st);
    issue(3'b101, 32'd100, 32'd7, 32'd14, "divu_100_7", 1'b0, st);
    issue(3'b111, 32'd100, 32'd7, 32'd2, "remu_100_7", 1'b0, st);
    drain();
  endtask

  task automatic test_special();
    int st;
    issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0", 1'b0, st);
    issue(3'b110, 32'd5, 32'd0, 32'd5, "rem_by0", 1'b0, st);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 1'b0, st);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf", 1'b0, st);
    drain();
  endtask

  task automatic test_flush();
    int st;
    int vc;
    issue(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, "div_flushed", 1'b0, st);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b expected 1", ready); end
    vc = valid_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (valid_cnt != vc) begin failures++; $display("FAIL flush_no_valid: pulses %0d expected 0", valid_cnt - vc); end
    issue(3'b000, 32'd3, 32'd3, 32'd9, "mul_after_flush", 1'b0, st);
    drain();
    // Flush together with a request in IDLE: the request must be dropped.
    flush = 1'b1;
    valid = 1'b1;
    md_op = 3'b000;
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL flush_beats_valid: ready=%b expected 1", ready); end
    // Flush in the DONE cycle of a shortcut op kills the pulse and keeps old data.
    vc = valid_cnt;
    issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_done_flush", 1'b0, st);
    flush = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_cnt != vc) begin failures++; $display("FAIL done_flush_valid: pulses %0d expected 0", valid_cnt - vc); end
    checks++;
    if (md_data !== 32'd9) begin failures++; $display("FAIL done_flush_data: got %h expected 9", md_data); end
  endtask

  task automatic test_hold_valid();
    int st;
    int n = 0;
    int bad = 0;
    issue(3'b000, 32'd5, 32'd7, 32'd35, "mul_hold", 1'b1, st);
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 60) begin
      if (ready !== 1'b0) bad++;
      operand_a = $urandom;
      operand_b = $urandom;
      @(negedge clk);
      n++;
    end
    valid = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL hold_ready_low: ready high %0d cycles expected 0", bad); end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL hold_pending: %0d outstanding expected 0", sb.size()); sb.delete(); end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL hold_ready_idle: got %b expected 1", ready); end
  endtask

  task automatic test_reset_mid();
    int st;
    int vc;
    issue(3'b101, 32'd1000, 32'd3, 32'd333, "divu_reset", 1'b0, st);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++;
    if (md_data !== 32'h0) begin failures++; $display("FAIL midrst_data: got %h expected 0", md_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    vc = valid_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (valid_cnt != vc) begin failures++; $display("FAIL midrst_no_valid: pulses %0d expected 0", valid_cnt - vc); end
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom | 32'h1;
    issue(3'b000, a, b, model(3'b000, a, b), "b2b_mul", 1'b0, s0);
    issue(3'b101, a, b, model(3'b101, a, b), "b2b_divu", 1'b0, s1);
    issue(3'b110, a, b, model(3'b110, a, b), "b2b_rem", 1'b0, s2);
    checks++;
    if (s1 - s0 != 34) begin failures++; $display("FAIL b2b_period1: got %0d expected 34", s1 - s0); end
    checks++;
    if (s2 - s1 != 34) begin failures++; $display("FAIL b2b_period2: got %0d expected 34", s2 - s1); end
    drain();
  endtask

  task automatic test_random();
    int st;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (i % 4 == 1) a = -a;
      issue(op, a, b, model(op, a, b), $sformatf("rand%0d_op%0d", i, op), 1'b0, st);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_hold_valid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit. It sits beside the single-cycle ALU in the execute stage and takes the M-extension ops (funct3-encoded) that the ALU does not implement.
- Operands are latched on a valid/ready handshake. The unit runs one radix-2 step per cycle and returns a registered result with a one-cycle valid pulse.
- The hazard/stall logic holds the pipeline while o_ready is low.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- M_MUL, 3'b000, low WIDTH bits of a*b.
- M_MULH, 3'b001, high WIDTH bits of signed*signed.
- M_MULHSU, 3'b010, high WIDTH bits of signed*unsigned.
- M_MULHU, 3'b011, high WIDTH bits of unsigned*unsigned.
- M_DIV, 3'b100, signed quotient.
- M_DIVU, 3'b101, unsigned quotient.
- M_REM, 3'b110, signed remainder.
- M_REMU, 3'b111, unsigned remainder.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset: synchronous, active-high.
- i_flush  input  1  abort any in-flight operation (pipeline flush).
- i_valid  input  1  request valid.
- o_ready  output  1  unit idle and able to accept a request.
- i_md_op  input  3  operation, encoded per the parameters above.
- i_operand_a  input  WIDTH  rs1 value.
- i_operand_b  input  WIDTH  rs2 value.
- o_valid  output  1  result valid, one-cycle pulse.
- o_md_data  output  WIDTH  result; held stable until the next o_valid.

Behaviour:
- Reset: state=IDLE, o_ready=1, o_valid=0, o_md_data=0, iteration counter=0, all internal registers cleared. A reset asserted mid-operation discards the operation with no o_valid.
- Acceptance: a request is accepted in a cycle where i_valid && o_ready && !i_flush.
  - i_md_op and both operands are latched on acceptance. Later input changes are ignored.
- FSM states:
  - IDLE: o_ready=1. On acceptance, go to CALC, or go straight to DONE for a special case.
  - CALC: o_ready=0. Perform one iteration per cycle and decrement the counter from WIDTH. After the WIDTH-th iteration, go to DONE.
  - DONE: o_ready=0, o_valid=1 for exactly this cycle, o_md_data valid. Next state is IDLE. A request presented in DONE is not accepted.
- Latency: o_valid is asserted WIDTH+1 cycles after the acceptance cycle (33 for WIDTH=32). For special cases it is asserted 1 cycle after acceptance. Back-to-back throughput is one op per WIDTH+2 cycles.
- Multiply:
  - Shift-add on operand magnitudes, producing a 2*WIDTH-bit product.
  - Signedness per op: MULH both signed; MULHSU a signed, b unsigned; MULHU and MUL unsigned magnitudes.
  - Final product negated (two's complement, 2*WIDTH bits) when exactly one signed operand is negative.
  - MUL returns product[WIDTH-1:0] (identical for any signedness). The MULH* ops return product[2W-1:W].
- Divide:
  - Restoring division on magnitudes for DIV/REM and raw values for DIVU/REMU.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases (resolved on acceptance, no iteration):
  - Divisor==0: DIV/DIVU return all-ones (0xFFFFFFFF); REM/REMU return the dividend.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Flush:
  - i_flush in CALC or DONE returns the unit to IDLE on the next edge and suppresses o_valid (a DONE-cycle flush kills the pulse). o_md_data is not updated.
  - i_flush together with i_valid in IDLE: flush wins, the request is not accepted.
- Simultaneous events: i_rst has priority over i_flush, which has priority over i_valid.
- The counter never wraps: it only loads on acceptance and stops at 0.

Test Plan:
- Reset, then MUL a=7 b=6 -> o_ready falls next cycle; o_valid pulses exactly 33 cycles after acceptance with o_md_data=42; o_ready returns 1 the cycle after.
- MULH a=0xFFFFFFFF(-1) b=0xFFFFFFFF(-1) -> 0x00000000. MULHU with the same operands -> 0xFFFFFFFE. MULHSU a=-1 b=2 -> 0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9) b=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU a=100 b=7 -> 14. REMU with the same operands -> 2.
- DIVU a=5 b=0 -> 0xFFFFFFFF. REM a=5 b=0 -> 5. DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. Each special case gives o_valid 1 cycle after acceptance.
- Accept DIV, then assert i_flush at cycle 10 -> no o_valid ever; o_ready=1 next cycle; a new MUL 3*3 is accepted and returns 9 at the normal latency.
- Hold i_valid high through a whole op while changing operands mid-CALC -> result uses the latched values, no second acceptance before IDLE. i_rst asserted mid-CALC -> all outputs at reset values next cycle.
